// File: rtl/start_lights_seq_if.sv
// Bus between the reaction-game controller and the start-light sequencer.
// The master drives the strobes, trigger/response levels and the random
// delay; the slave (the sequencer) returns the lights and the result.
interface start_lights_seq_if #(
   parameter int N_LIGHTS = 10,
   parameter int DELAY_W  = 11,
   parameter int RT_W     = 12
) ();
   logic                tick;
   logic                ms_tick;
   logic                trigger;
   logic                resp;
   logic [DELAY_W-1:0]  rand_val;
   logic                lfsr_en;
   logic [N_LIGHTS-1:0] ledr;
   logic                go;
   logic                busy;
   logic                false_start;
   logic                timeout;
   logic                react_valid;
   logic [RT_W-1:0]     react_time;

   modport master (
      output tick, ms_tick, trigger, resp, rand_val,
      input  lfsr_en, ledr, go, busy, false_start, timeout, react_valid, react_time
   );

   modport slave (
      input  tick, ms_tick, trigger, resp, rand_val,
      output lfsr_en, ledr, go, busy, false_start, timeout, react_valid, react_time
   );
endinterface

// File: rtl/start_lights_seq.sv
// Start-light sequencer and reaction timer: lights N_LIGHTS LEDs one per
// tick, holds for MIN_DELAY + rand_val ms, blanks the lights with a go
// pulse, then times the player's response with false-start and timeout
// detection. Every output comes straight from a flop.
module start_lights_seq #(
   parameter int N_LIGHTS  = 10,
   parameter int DELAY_W   = 11,
   parameter int MIN_DELAY = 200,
   parameter int RT_W      = 12,
   parameter int MAX_REACT = 2000
) (
   input logic               clk,
   input logic               rst_n,
   start_lights_seq_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_LIGHT, S_HOLD, S_REACT, S_DONE, S_FAULT
   } state_t;

   localparam int                IDX_W    = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1;
   localparam int                DLY_W    = DELAY_W + 1;
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_LIGHTS - 1);
   localparam logic [RT_W-1:0]   MAX_RC   = RT_W'(MAX_REACT);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DLY_W-1:0]    dly_q, dly_d;
   logic [RT_W-1:0]     rc_q, rc_d;
   logic                trig_prev_q, resp_prev_q;
   logic [N_LIGHTS-1:0] ledr_q, ledr_d;
   logic                go_q, go_d;
   logic                busy_q, busy_d;
   logic                lfsr_en_q, lfsr_en_d;
   logic                false_start_q, false_start_d;
   logic                timeout_q, timeout_d;
   logic                react_valid_q, react_valid_d;
   logic [RT_W-1:0]     react_time_q, react_time_d;

   logic                trig_edge, resp_edge;
   logic [DLY_W-1:0]    dly_sum;
   logic [RT_W-1:0]     rc_inc;

   // Previous-value flops reset high, so a level held through reset is no edge.
   assign trig_edge = bus.trigger & ~trig_prev_q;
   assign resp_edge = bus.resp    & ~resp_prev_q;

   // Hold delay is widened by one bit so MIN_DELAY + rand_val never wraps.
   assign dly_sum = DLY_W'(MIN_DELAY) + {1'b0, bus.rand_val};
   assign rc_inc  = rc_q + RT_W'(1);

   // Next-state and next-output logic for the run sequence.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
      state_d       = state_q;
      idx_d         = idx_q;
      dly_d         = dly_q;
      rc_d          = rc_q;
      ledr_d        = ledr_q;
      go_d          = 1'b0;
      false_start_d = false_start_q;
      timeout_d     = timeout_q;
      react_valid_d = react_valid_q;
      react_time_d  = react_time_q;

      unique case (state_q)
         S_IDLE, S_DONE, S_FAULT: begin
            if (trig_edge) begin
               state_d       = S_LIGHT;
               idx_d         = '0;
               ledr_d        = '0;
               false_start_d = 1'b0;
               timeout_d     = 1'b0;
               react_valid_d = 1'b0;
               react_time_d  = '0;
            end
         end
         S_LIGHT: begin
            if (resp_edge) begin
               state_d       = S_FAULT;
               false_start_d = 1'b1;
               ledr_d        = '1;
            end else if (bus.tick) begin
               ledr_d[idx_q] = 1'b1;
               if (idx_q == LAST_IDX) begin
                  state_d = S_HOLD;
                  dly_d   = (dly_sum == '0) ? DLY_W'(1) : dly_sum;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         S_HOLD: begin
            if (resp_edge) begin
               state_d       = S_FAULT;
               false_start_d = 1'b1;
               ledr_d        = '1;
            end else if (bus.ms_tick) begin
               if (dly_q <= DLY_W'(1)) begin
                  state_d = S_REACT;
                  ledr_d  = '0;
                  go_d    = 1'b1;
                  rc_d    = '0;
               end else begin
                  dly_d = dly_q - DLY_W'(1);
               end
            end
         end
         S_REACT: begin
            if (resp_edge) begin
               state_d       = S_DONE;
               react_time_d  = rc_q;
               react_valid_d = 1'b1;
            end else if (bus.ms_tick) begin
               rc_d = rc_inc;
               if (rc_inc == MAX_RC) begin
                  state_d      = S_DONE;
                  timeout_d    = 1'b1;
                  react_time_d = MAX_RC;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d    = (state_d == S_LIGHT) || (state_d == S_HOLD) || (state_d == S_REACT);
      lfsr_en_d = (state_d == S_LIGHT) || (state_d == S_HOLD);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= S_IDLE;
         idx_q         <= '0;
         dly_q         <= '0;
         rc_q          <= '0;
         trig_prev_q   <= 1'b1;
         resp_prev_q   <= 1'b1;
         ledr_q        <= '0;
         go_q          <= 1'b0;
         busy_q        <= 1'b0;
         lfsr_en_q     <= 1'b0;
         false_start_q <= 1'b0;
         timeout_q     <= 1'b0;
         react_valid_q <= 1'b0;
         react_time_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q       <= state_d;
         idx_q         <= idx_d;
         dly_q         <= dly_d;
         rc_q          <= rc_d;
         trig_prev_q   <= bus.trigger;
         resp_prev_q   <= bus.resp;
         ledr_q        <= ledr_d;
         go_q          <= go_d;
         busy_q        <= busy_d;
         lfsr_en_q     <= lfsr_en_d;
         false_start_q <= false_start_d;
         timeout_q     <= timeout_d;
         react_valid_q <= react_valid_d;
         react_time_q  <= react_time_d;
      end
   end

   assign bus.ledr        = ledr_q;
   assign bus.go          = go_q;
   assign bus.busy        = busy_q;
   assign bus.lfsr_en     = lfsr_en_q;
   assign bus.false_start = false_start_q;
   assign bus.timeout     = timeout_q;
   assign bus.react_valid = react_valid_q;
   assign bus.react_time  = react_time_q;
endmodule

// File: tb/tb_start_lights_seq.sv
// Directed bench for start_lights_seq: expected values are queued as each
// stimulus step is driven and popped when the resulting outputs are sampled.
module tb_start_lights_seq;
   localparam int N_LIGHTS  = 4;
   localparam int DELAY_W   = 4;
   localparam int MIN_DELAY = 3;
   localparam int RT_W      = 6;
   localparam int MAX_REACT = 20;

   logic clk;
   logic rst_n;

   start_lights_seq_if #(.N_LIGHTS(N_LIGHTS), .DELAY_W(DELAY_W), .RT_W(RT_W)) ifc ();
   start_lights_seq_if #(.N_LIGHTS(N_LIGHTS), .DELAY_W(DELAY_W), .RT_W(RT_W)) zfc ();

   start_lights_seq #(
      .N_LIGHTS(N_LIGHTS), .DELAY_W(DELAY_W), .MIN_DELAY(MIN_DELAY),
      .RT_W(RT_W), .MAX_REACT(MAX_REACT)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   start_lights_seq #(
      .N_LIGHTS(N_LIGHTS), .DELAY_W(DELAY_W), .MIN_DELAY(0),
      .RT_W(RT_W), .MAX_REACT(MAX_REACT)
   ) u_dut_zero (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (zfc.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   string       sb_tag[$];
   logic [31:0] sb_exp[$];
   int          n_total = 0;
   int          n_pass  = 0;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_v(input string tag, input logic [31:0] v);
      sb_tag.push_back(tag);
      sb_exp.push_back(v);
   endtask

   task automatic check_v(input logic [31:0] obs);
      string       tag;
      logic [31:0] e;
      n_total++;
      if (sb_exp.size() == 0) begin
         $error("FAIL scoreboard_empty: observed %0h expected none", obs);
      end else begin
         tag = sb_tag.pop_front();
         e   = sb_exp.pop_front();
         assert (obs === e) begin
            n_pass++;
         end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
         end
      end
   endtask

   task automatic trig_edge();
      ifc.trigger = 1'b1;
      cyc();
      ifc.trigger = 1'b0;
   endtask

   task automatic pulse_tick(input logic [DELAY_W-1:0] rv);
      ifc.rand_val = rv;
      ifc.tick     = 1'b1;
      cyc();
      ifc.tick     = 1'b0;
   endtask

   task automatic pulse_ms();
      ifc.ms_tick = 1'b1;
      cyc();
      ifc.ms_tick = 1'b0;
   endtask

   // Trigger, all lights, and the full 5 ms hold: leaves the DUT in REACT.
   task automatic run_to_react();
      trig_edge();
      for (int i = 0; i < N_LIGHTS; i++) pulse_tick(4'd2);
      for (int i = 0; i < MIN_DELAY + 2; i++) pulse_ms();
   endtask

   initial begin
      ifc.tick = 1'b0; ifc.ms_tick = 1'b0; ifc.resp = 1'b0; ifc.rand_val = '0;
      ifc.trigger = 1'b1;
      zfc.tick = 1'b0; zfc.ms_tick = 1'b0; zfc.resp = 1'b0; zfc.rand_val = '0;
      zfc.trigger = 1'b0;
      rst_n = 1'b0;

      // Reset state with trigger held high.
      repeat (2) cyc();
      expect_v("rst_ledr", 0);    expect_v("rst_busy", 0);    expect_v("rst_lfsr", 0);
      expect_v("rst_go", 0);      expect_v("rst_rtime", 0);   expect_v("rst_valid", 0);
      check_v(32'(ifc.ledr));     check_v(32'(ifc.busy));     check_v(32'(ifc.lfsr_en));
      check_v(32'(ifc.go));       check_v(32'(ifc.react_time)); check_v(32'(ifc.react_valid));
      rst_n = 1'b1;
      expect_v("held_trig_idle", 0);
      repeat (3) cyc();
      check_v(32'(ifc.busy));
      ifc.trigger = 1'b0;
      cyc();

      // Normal run.
      expect_v("start_busy", 1); expect_v("start_lfsr", 1); expect_v("start_ledr", 0);
      trig_edge();
      check_v(32'(ifc.busy)); check_v(32'(ifc.lfsr_en)); check_v(32'(ifc.ledr));
      expect_v("tick1_ledr", 4'b0001); pulse_tick(4'd9); check_v(32'(ifc.ledr));
      expect_v("tick2_ledr", 4'b0011); pulse_tick(4'd9); check_v(32'(ifc.ledr));
      expect_v("tick3_ledr", 4'b0111); pulse_tick(4'd9); check_v(32'(ifc.ledr));
      expect_v("tick4_ledr", 4'b1111); pulse_tick(4'd2); check_v(32'(ifc.ledr));
      // Trigger during HOLD is ignored.
      expect_v("hold_trig_busy", 1); expect_v("hold_trig_ledr", 4'b1111);
      trig_edge(); cyc();
      check_v(32'(ifc.busy)); check_v(32'(ifc.ledr));
      for (int i = 1; i <= 4; i++) begin
         expect_v($sformatf("hold_ms%0d_go", i), 0);
         expect_v($sformatf("hold_ms%0d_ledr", i), 4'b1111);
         pulse_ms();
         check_v(32'(ifc.go)); check_v(32'(ifc.ledr));
      end
      expect_v("go_pulse", 1); expect_v("go_ledr", 0); expect_v("go_lfsr", 0); expect_v("go_busy", 1);
      pulse_ms();
      check_v(32'(ifc.go)); check_v(32'(ifc.ledr)); check_v(32'(ifc.lfsr_en)); check_v(32'(ifc.busy));
      expect_v("go_low", 0);
      cyc();
      check_v(32'(ifc.go));
      repeat (7) pulse_ms();
      expect_v("react_time", 7); expect_v("react_valid", 1); expect_v("react_busy", 0); expect_v("react_tout", 0);
      ifc.resp = 1'b1;
      cyc();
      check_v(32'(ifc.react_time)); check_v(32'(ifc.react_valid)); check_v(32'(ifc.busy)); check_v(32'(ifc.timeout));
      // Held resp and later ms_ticks change nothing.
      expect_v("react_hold_time", 7);
      repeat (3) pulse_ms();
      check_v(32'(ifc.react_time));
      ifc.resp = 1'b0;
      cyc();

      // False start after the 2nd tick.
      expect_v("fs_clr_valid", 0); expect_v("fs_clr_time", 0);
      trig_edge();
      check_v(32'(ifc.react_valid)); check_v(32'(ifc.react_time));
      pulse_tick(4'd2); pulse_tick(4'd2);
      expect_v("fs_flag", 1); expect_v("fs_ledr", 4'b1111); expect_v("fs_lfsr", 0); expect_v("fs_busy", 0);
      ifc.resp = 1'b1;
      cyc();
      ifc.resp = 1'b0;
      check_v(32'(ifc.false_start)); check_v(32'(ifc.ledr)); check_v(32'(ifc.lfsr_en)); check_v(32'(ifc.busy));
      expect_v("fs_tick_ledr", 4'b1111); expect_v("fs_tick_busy", 0);
      pulse_tick(4'd2);
      check_v(32'(ifc.ledr)); check_v(32'(ifc.busy));
      expect_v("rearm_fs", 0); expect_v("rearm_ledr", 0); expect_v("rearm_busy", 1);
      trig_edge();
      check_v(32'(ifc.false_start)); check_v(32'(ifc.ledr)); check_v(32'(ifc.busy));

      // Timeout: continue the re-armed run with no response.
      for (int i = 0; i < N_LIGHTS; i++) pulse_tick(4'd2);
      repeat (MIN_DELAY + 2) pulse_ms();
      repeat (MAX_REACT - 1) pulse_ms();
      expect_v("pre_tout_busy", 1); expect_v("pre_tout_flag", 0);
      check_v(32'(ifc.busy)); check_v(32'(ifc.timeout));
      expect_v("tout_flag", 1); expect_v("tout_time", MAX_REACT); expect_v("tout_valid", 0); expect_v("tout_busy", 0);
      pulse_ms();
      check_v(32'(ifc.timeout)); check_v(32'(ifc.react_time)); check_v(32'(ifc.react_valid)); check_v(32'(ifc.busy));

      // Collision: resp edge with the final hold ms_tick.
      trig_edge();
      for (int i = 0; i < N_LIGHTS; i++) pulse_tick(4'd2);
      repeat (MIN_DELAY + 1) pulse_ms();
      expect_v("col_hold_fs", 1); expect_v("col_hold_go", 0); expect_v("col_hold_ledr", 4'b1111);
      ifc.resp = 1'b1; ifc.ms_tick = 1'b1;
      cyc();
      ifc.resp = 1'b0; ifc.ms_tick = 1'b0;
      check_v(32'(ifc.false_start)); check_v(32'(ifc.go)); check_v(32'(ifc.ledr));
      expect_v("col_hold_go_late", 0);
      cyc();
      check_v(32'(ifc.go));

      // Collision: resp edge with the MAX_REACT-th react ms_tick.
      run_to_react();
      repeat (MAX_REACT - 1) pulse_ms();
      expect_v("col_react_time", MAX_REACT - 1); expect_v("col_react_valid", 1); expect_v("col_react_tout", 0);
      ifc.resp = 1'b1; ifc.ms_tick = 1'b1;
      cyc();
      ifc.resp = 1'b0; ifc.ms_tick = 1'b0;
      check_v(32'(ifc.react_time)); check_v(32'(ifc.react_valid)); check_v(32'(ifc.timeout));
      cyc();

      // Asynchronous reset while in REACT.
      run_to_react();
      repeat (3) pulse_ms();
      expect_v("pre_rst_busy", 1);
      check_v(32'(ifc.busy));
      rst_n = 1'b0;
      #2;
      expect_v("arst_busy", 0); expect_v("arst_ledr", 0); expect_v("arst_lfsr", 0);
      expect_v("arst_go", 0);   expect_v("arst_fs", 0);   expect_v("arst_tout", 0);
      check_v(32'(ifc.busy)); check_v(32'(ifc.ledr)); check_v(32'(ifc.lfsr_en));
      check_v(32'(ifc.go));   check_v(32'(ifc.false_start)); check_v(32'(ifc.timeout));
      cyc();
      rst_n = 1'b1;
      expect_v("post_rst_idle", 0);
      repeat (2) pulse_ms();
      check_v(32'(ifc.busy));

      // Zero delay on the MIN_DELAY=0 instance.
      zfc.trigger = 1'b1; cyc(); zfc.trigger = 1'b0;
      for (int i = 0; i < N_LIGHTS; i++) begin
         zfc.tick = 1'b1; cyc(); zfc.tick = 1'b0;
      end
      expect_v("zero_ledr_full", 4'b1111); expect_v("zero_no_go", 0);
      cyc();
      check_v(32'(zfc.ledr)); check_v(32'(zfc.go));
      expect_v("zero_go", 1); expect_v("zero_ledr_off", 0);
      zfc.ms_tick = 1'b1; cyc(); zfc.ms_tick = 1'b0;
      check_v(32'(zfc.go)); check_v(32'(zfc.ledr));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/start_lights_seq.md
# start_lights_seq

Parametrised start-light sequencer and reaction timer for the reaction-game datapath. A trigger edge lights N_LIGHTS LEDs one per `tick` and holds them for a randomised delay taken from the external LFSR. It then extinguishes all lights, pulses `go`, and measures the player's response in `ms_tick` units. It adds false-start detection, a reaction timeout and re-arm from any finished state.

## Interface
- N_LIGHTS, 10, number of start lights (1..32)
- DELAY_W, 11, width of `rand_val`
- MIN_DELAY, 200, fixed hold delay in ms_ticks added to `rand_val`
- RT_W, 12, reaction-time counter width
- MAX_REACT, 2000, timeout in ms_ticks (< 2^RT_W)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tick  in  1  one-cycle strobe, light step rate
- ms_tick  in  1  one-cycle strobe, 1 ms
- trigger  in  1  start request, level, already synchronised
- resp  in  1  player button, level, already synchronised
- rand_val  in  DELAY_W  random delay from LFSR
- lfsr_en  out  1  LFSR run enable
- ledr  out  N_LIGHTS  start lights
- go  out  1  one-cycle pulse at lights-out
- busy  out  1  run in progress
- false_start  out  1  sticky false-start flag
- timeout  out  1  sticky timeout flag
- react_valid  out  1  sticky result-valid flag
- react_time  out  RT_W  measured reaction in ms_ticks

## Operation
- All outputs are registered. Reset value of every output is 0, and the state resets to IDLE.
- Edge detection: the previous-value registers for `trigger` and `resp` reset to 1. A level held high through reset release produces no edge.
- States: IDLE, LIGHT, HOLD, REACT, DONE, FAULT.
- `busy` = 1 in LIGHT, HOLD and REACT. `lfsr_en` = 1 only in LIGHT and HOLD.
- IDLE, DONE, FAULT:
  - A trigger rising edge enters LIGHT.
  - On entry, clear `ledr`, `false_start`, `timeout`, `react_valid` and `react_time`, and set the light index to 0.
- LIGHT:
  - Each tick sets `ledr[idx]` and increments `idx`.
  - On the tick that sets `ledr[N_LIGHTS-1]`, enter HOLD and load `dly` = MIN_DELAY + `rand_val`, computed in DELAY_W+1 bits with no wrap. `rand_val` is sampled in that cycle.
  - `dly` = 0 is treated as 1.
- HOLD:
  - Each ms_tick decrements `dly`.
  - On the ms_tick where `dly` = 1, enter REACT, set `ledr` to 0, pulse `go`, and clear the counter `rc`.
- REACT:
  - Each ms_tick increments `rc`.
  - A resp rising edge enters DONE with `react_time` = `rc` (an ms_tick in the same cycle is not counted) and `react_valid` = 1.
  - If `rc` reaches MAX_REACT, enter DONE with `timeout` = 1 and `react_time` = MAX_REACT.
- False start: a resp rising edge in LIGHT or HOLD enters FAULT with `false_start` = 1, `ledr` all ones and `lfsr_en` = 0.
- Trigger edges are ignored in LIGHT, HOLD and REACT.
- Precedence in the same cycle:
  - resp edge beats a tick (LIGHT).
  - resp edge beats delay expiry (HOLD); the result is FAULT.
  - resp edge beats reaching MAX_REACT (REACT); the result is valid, not timeout.
- Holding `resp` continuously gives a single edge. No re-measurement occurs until the next trigger.
- `ledr` in DONE is all zeros. `react_time`, `react_valid`, `timeout` and `false_start` hold until the next trigger edge or reset.
- Reset asserted mid-run returns immediately to IDLE with all outputs 0.

## Timing
- Trigger edge in cycle T: state is LIGHT and `busy` = 1 at T+1.
- Tick k (k = 1..N_LIGHTS) in cycle T: `ledr[k-1]` = 1 at T+1. After tick N_LIGHTS: `ledr` is all ones and the state is HOLD at T+1.
- HOLD lasts exactly D ms_ticks, where D = max(1, MIN_DELAY + `rand_val`).
- The D-th ms_tick in cycle T gives `go` = 1 and `ledr` = 0 at T+1, with `go` low again at T+2.
- A resp edge in cycle T (REACT) gives `react_valid` = 1, `react_time` valid and `busy` = 0 at T+1.
- The false-start response appears one cycle after the resp edge.
- The timeout flag is set one cycle after the ms_tick that brings `rc` to MAX_REACT.
- There is no combinational path from any input to any output.

## Test plan
Bench parameters: N_LIGHTS=4, MIN_DELAY=3, MAX_REACT=20, DELAY_W=4, RT_W=6.
- Normal run: trigger edge, 4 ticks, `rand_val`=2 at the 4th tick, then 5 ms_ticks → `ledr` goes 0001, 0011, 0111, 1111, then 0000 with a single `go` pulse after the 5th ms_tick. Then 7 ms_ticks and a resp edge → `react_time`=7, `react_valid`=1, `busy`=0.
- False start: resp edge after the 2nd tick → `false_start`=1, `ledr`=1111, `lfsr_en`=0. A further tick has no effect. A new trigger edge clears all flags and restarts LIGHT.
- Timeout: normal run with no resp → `timeout`=1 and `react_time`=20 after 20 ms_ticks in REACT, `react_valid`=0.
- Collisions:
  - resp edge in the same cycle as the 5th hold ms_tick → FAULT, no `go` pulse.
  - resp edge in the same cycle as the 20th react ms_tick → `react_time`=19, `react_valid`=1, `timeout`=0.
- Reset and edges:
  - `trigger` held high through `rst_n` release → stays IDLE.
  - Trigger edge during HOLD is ignored.
  - `rst_n` pulsed low in REACT → all outputs 0 asynchronously, state IDLE.
- Zero delay: `rand_val`=0 with MIN_DELAY overridden to 0 → HOLD lasts exactly 1 ms_tick.
